// File: rtl/wb_pwm_sequencer.sv
// Wishbone master that sweeps per-channel triangle-wave duties
// and writes them to the LED PWM slave once per tick period.
module wb_pwm_sequencer #(
  parameter int CHANNELS    = 3,
  parameter int BITS        = 5,
  parameter int TICK_CYCLES = 65536,
  parameter int TIMEOUT     = 255
) (
  input  logic        i_wb_clk,
  input  logic        i_wb_rst_n,
  input  logic        i_en,
  output logic        o_wb_cyc,
  output logic        o_wb_stb,
  output logic        o_wb_we,
  output logic [31:0] o_wb_addr,
  output logic [31:0] o_wb_data,
  input  logic        i_wb_stall,
  input  logic        i_wb_ack,
  output logic        o_frame_done,
  output logic        o_err
);

  localparam int IW   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int KW   = $clog2(TICK_CYCLES + 1);
  localparam int TW   = $clog2(TIMEOUT + 1);
  localparam int SPAN = (1 << BITS) / CHANNELS;
  localparam logic [BITS-1:0] MAX = '1;

  typedef enum logic [1:0] {
    IDLE,
    REQUEST,
    WAIT_ACK,
    DONE
  } state_e;

  state_e              state_q, state_d;
  logic [KW-1:0]       tick_q, tick_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [TW-1:0]       timer_q, timer_d;
  logic                err_q, err_d;
  logic                step;
  logic [BITS-1:0]     duty_q [CHANNELS];
  logic [BITS-1:0]     duty_d [CHANNELS];
  logic [CHANNELS-1:0] up_q, up_d;
  logic [BITS-1:0]     cur_duty;

  always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
    if (!i_wb_rst_n) begin
      state_q <= IDLE;
      tick_q  <= '0;
      idx_q   <= '0;
      timer_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      idx_q   <= idx_d;
      timer_q <= timer_d;
      err_q   <= err_d;
    end
  end

  // Duties start evenly spread so channels sweep out of phase.
  always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
    if (!i_wb_rst_n) begin
      for (int k = 0; k < CHANNELS; k++) begin
        duty_q[k] <= BITS'(k * SPAN);
      end
      up_q <= '1;
    end else if (step) begin
      duty_q <= duty_d;
      up_q   <= up_d;
    end
  end

  always_comb begin
    for (int k = 0; k < CHANNELS; k++) begin
      duty_d[k] = duty_q[k];
      up_d[k]   = up_q[k];
      if (up_q[k]) begin
        if (duty_q[k] == MAX) begin
          duty_d[k] = MAX - 1'b1;
          up_d[k]   = 1'b0;
        end else begin
          duty_d[k] = duty_q[k] + 1'b1;
        end
      end else if (duty_q[k] == '0) begin
        duty_d[k] = BITS'(1);
        up_d[k]   = 1'b1;
      end else begin
        duty_d[k] = duty_q[k] - 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    idx_d   = idx_q;
    timer_d = timer_q;
    err_d   = 1'b0;
    step    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!i_en) begin
          tick_d = '0;
        end else if (tick_q == KW'(TICK_CYCLES - 1)) begin
          tick_d  = '0;
          idx_d   = '0;
          step    = 1'b1;
          state_d = REQUEST;
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      REQUEST: begin
        if (!i_wb_stall) begin
          timer_d = '0;
          state_d = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (i_wb_ack) begin
          if (idx_q == IW'(CHANNELS - 1)) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = REQUEST;
          end
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      DONE: begin
        tick_d  = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cur_duty = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (idx_q == IW'(k)) cur_duty = duty_q[k];
    end
  end

  always_comb begin
    o_wb_cyc     = 1'b0;
    o_wb_stb     = 1'b0;
    o_wb_we      = 1'b0;
    o_wb_addr    = '0;
    o_wb_data    = '0;
    o_frame_done = 1'b0;
    o_err        = 1'b0;
    unique case (state_q)
      REQUEST: begin
        o_wb_cyc  = 1'b1;
        o_wb_stb  = 1'b1;
        o_wb_we   = 1'b1;
        o_wb_addr = {{(32-IW){1'b0}}, idx_q};
        o_wb_data = {{(32-BITS){1'b0}}, cur_duty};
      end
      WAIT_ACK: o_wb_cyc = 1'b1;
      DONE: begin
        o_frame_done = 1'b1;
        o_err        = err_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_wb_pwm_sequencer.sv
// Directed bench for wb_pwm_sequencer with a small
// stall/ack slave model and a triangle-wave duty model.
module tb_wb_pwm_sequencer;

  localparam int CH   = 3;
  localparam int BITS = 5;
  localparam int TICK = 4;
  localparam int TO   = 5;
  localparam int MAXV = 31;

  logic        clk = 1'b0;
  logic        rst_n, en;
  logic        cyc, stb, we, stall, ack, done, err;
  logic [31:0] addr, data;

  always #5 clk = ~clk;

  wb_pwm_sequencer #(
    .CHANNELS(CH),
    .BITS(BITS),
    .TICK_CYCLES(TICK),
    .TIMEOUT(TO)
  ) dut (
    .i_wb_clk(clk),
    .i_wb_rst_n(rst_n),
    .i_en(en),
    .o_wb_cyc(cyc),
    .o_wb_stb(stb),
    .o_wb_we(we),
    .o_wb_addr(addr),
    .o_wb_data(data),
    .i_wb_stall(stall),
    .i_wb_ack(ack),
    .o_frame_done(done),
    .o_err(err)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // slave model: stalls a chosen address, acks the cycle after accept
  logic [31:0] stall_addr = '1;
  logic [31:0] noack_addr = '1;
  int          stall_left = 0;

  always_comb stall = stb && (addr == stall_addr) && (stall_left > 0);

  initial ack = 1'b0;
  always begin
    logic        acc, st;
    logic [31:0] ad;
    @(posedge clk);
    acc = stb && !stall;
    st  = stb && stall;
    ad  = addr;
    #1;
    ack = acc && (ad != noack_addr);
    if (st) stall_left = stall_left - 1;
  end

  // reference duty model
  int md [CH];
  bit mup [CH];

  function automatic void minit();
    for (int k = 0; k < CH; k++) begin
      md[k]  = k * ((MAXV + 1) / CH);
      mup[k] = 1'b1;
    end
  endfunction

  function automatic void mstep();
    for (int k = 0; k < CH; k++) begin
      if (mup[k]) begin
        if (md[k] == MAXV) begin md[k] = MAXV - 1; mup[k] = 1'b0; end
        else md[k] = md[k] + 1;
      end else begin
        if (md[k] == 0) begin md[k] = 1; mup[k] = 1'b1; end
        else md[k] = md[k] - 1;
      end
    end
  endfunction

  logic [31:0] qa[$];
  logic [31:0] qd[$];
  int f_len, f_stb, f_err, f_errdone, f_drop, f_we, f_a1;
  int h0 [64];
  int h2 [64];

  task automatic wait_stb(output int n);
    n = -1;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (stb) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic run_frame(int drop_at);
    qa.delete();
    qd.delete();
    f_len = -1; f_stb = 0; f_err = 0;
    f_errdone = 0; f_drop = 0; f_we = 0; f_a1 = 0;
    for (int c = 0; c < 100; c++) begin
      if (c == drop_at) en = 1'b0;
      if (stb) f_stb++;
      if (we !== stb) f_we++;
      if (stb && addr == 32'd1) f_a1++;
      if (stb && !stall) begin
        qa.push_back(addr);
        qd.push_back(data);
      end
      if (!cyc && !done) f_drop++;
      if (err) f_err++;
      if (done) begin
        f_errdone = int'(err);
        f_len = c;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic normal_frame(int fno, int drop_at, output int n);
    wait_stb(n);
    chk("frame_start", 32'(n > 0), 32'd1);
    mstep();
    run_frame(drop_at);
    chk("frame_len", 32'(f_len), 32'd6);
    chk("n_accept", 32'(qa.size()), 32'd3);
    chk("cyc_drop", 32'(f_drop), 32'd0);
    chk("err_none", 32'(f_err), 32'd0);
    chk("we_eq_stb", 32'(f_we), 32'd0);
    for (int k = 0; k < CH && k < qa.size(); k++) begin
      chk("addr", qa[k], 32'(k));
      chk("data", qd[k], 32'(md[k]));
    end
    if (qd.size() == CH) begin
      h0[fno] = int'(qd[0]);
      h2[fno] = int'(qd[2]);
    end
  endtask

  initial begin
    int n, busy, wrap, d;
    rst_n = 1'b0;
    en    = 1'b1;
    minit();

    @(negedge clk);
    chk("rst_cyc", 32'(cyc), 32'd0);
    chk("rst_stb", 32'(stb), 32'd0);
    chk("rst_we", 32'(we), 32'd0);
    chk("rst_addr", addr, 32'd0);
    chk("rst_data", data, 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    rst_n = 1'b1;

    // frame 1: hand-computed duties 1/11/21
    wait_stb(n);
    chk("first_latency", 32'(n), 32'd4);
    mstep();
    run_frame(-1);
    chk("f1_len", 32'(f_len), 32'd6);
    chk("f1_stb_cycles", 32'(f_stb), 32'd3);
    chk("f1_n_accept", 32'(qa.size()), 32'd3);
    chk("f1_err", 32'(f_err), 32'd0);
    chk("f1_cyc_drop", 32'(f_drop), 32'd0);
    if (qa.size() == 3) begin
      chk("f1_a0", qa[0], 32'd0); chk("f1_d0", qd[0], 32'd1);
      chk("f1_a1", qa[1], 32'd1); chk("f1_d1", qd[1], 32'd11);
      chk("f1_a2", qa[2], 32'd2); chk("f1_d2", qd[2], 32'd21);
      h0[1] = int'(qd[0]);
      h2[1] = int'(qd[2]);
    end

    // frame 2: addr1 stalled for 3 cycles
    stall_addr = 32'd1;
    stall_left = 3;
    wait_stb(n);
    mstep();
    run_frame(-1);
    chk("f2_len", 32'(f_len), 32'd9);
    chk("f2_stb_cycles", 32'(f_stb), 32'd6);
    chk("f2_a1_hold", 32'(f_a1), 32'd4);
    chk("f2_n_accept", 32'(qa.size()), 32'd3);
    chk("f2_cyc_drop", 32'(f_drop), 32'd0);
    if (qa.size() == 3) begin
      chk("f2_a1", qa[1], 32'd1); chk("f2_d1", qd[1], 32'd12);
      chk("f2_a2", qa[2], 32'd2); chk("f2_d2", qd[2], 32'd22);
      h0[2] = int'(qd[0]);
      h2[2] = int'(qd[2]);
    end
    stall_addr = '1;

    // frames 3..34: sweep through both turn-arounds
    for (int f = 3; f <= 34; f++) normal_frame(f, -1, n);
    chk("d2_f11", 32'(h2[11]), 32'd31);
    chk("d2_f12", 32'(h2[12]), 32'd30);
    chk("d2_f13", 32'(h2[13]), 32'd29);
    chk("d0_f31", 32'(h0[31]), 32'd31);
    chk("d0_f32", 32'(h0[32]), 32'd30);
    chk("d0_f33", 32'(h0[33]), 32'd29);
    wrap = 0;
    for (int f = 2; f <= 34; f++) begin
      d = h0[f] - h0[f-1];
      if (d != 1 && d != -1) wrap++;
      d = h2[f] - h2[f-1];
      if (d != 1 && d != -1) wrap++;
    end
    chk("no_wrap", 32'(wrap), 32'd0);

    // frame 35: addr1 never acked -> timeout abort
    noack_addr = 32'd1;
    wait_stb(n);
    mstep();
    run_frame(-1);
    chk("to_len", 32'(f_len), 32'd8);
    chk("to_n_accept", 32'(qa.size()), 32'd2);
    chk("to_err_with_done", 32'(f_errdone), 32'd1);
    chk("to_err_pulses", 32'(f_err), 32'd1);
    chk("to_cyc_drop", 32'(f_drop), 32'd0);
    @(negedge clk);
    chk("to_cyc_after", 32'(cyc), 32'd0);
    chk("to_err_after", 32'(err), 32'd0);
    noack_addr = '1;
    normal_frame(36, -1, n);

    // enable held low: bus stays quiet, restart after TICK cycles
    en = 1'b0;
    busy = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (cyc || stb) busy++;
    end
    chk("en_low_quiet", 32'(busy), 32'd0);
    en = 1'b1;
    normal_frame(37, 1, n);
    chk("en_latency", 32'(n), 32'd4);
    busy = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (cyc || stb) busy++;
    end
    chk("en_drop_quiet", 32'(busy), 32'd0);

    // asynchronous reset in the middle of a request
    en = 1'b1;
    wait_stb(n);
    chk("pre_rst_stb", 32'(stb), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_cyc", 32'(cyc), 32'd0);
    chk("async_stb", 32'(stb), 32'd0);
    chk("async_we", 32'(we), 32'd0);
    minit();
    @(negedge clk);
    rst_n = 1'b1;
    wait_stb(n);
    chk("rst2_latency", 32'(n), 32'd4);
    run_frame(-1);
    chk("rst2_n_accept", 32'(qa.size()), 32'd3);
    if (qa.size() == 3) begin
      chk("rst2_d0", qd[0], 32'd1);
      chk("rst2_d1", qd[1], 32'd11);
      chk("rst2_d2", qd[2], 32'd21);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
